// File: rtl/reg_piso_ctrl.sv
// reg_piso_ctrl: parameterised parallel-in/serial-out shift register with
// a valid/ready load handshake, a bit counter and an end-of-frame pulse.
// Back-to-back words are accepted on the last bit of a frame, so consecutive
// frames run with no idle gap.
module reg_piso_ctrl #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0,
   localparam int CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] entrada,
   input  logic             carga_valid,
   output logic             carga_ready,
   input  logic             serie_in,
   output logic             salida,
   output logic             ocupado,
   output logic [CNT_W-1:0] pendientes,
   output logic             fin,
   output logic [WIDTH-1:0] paralelo
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shifted;
   logic             cnt_last;
   logic             accept;

   // Handshake and last-bit decode, all from registered state.
   always_comb begin
      cnt_last    = (cnt == CNT_W'(1));
      carga_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && cnt_last);
      accept      = enable && carga_valid && carga_ready;
   end

   // Next shift-register value: fill bit enters at the end opposite the output.
   always_comb begin
      shifted = '0;
      if (LSB_FIRST) begin
         shifted = {serie_in, q[WIDTH-1:1]};
      end else begin
         shifted = {q[WIDTH-2:0], serie_in};
      end
   end

   // Frame FSM, shift register and bit counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         q     <= '0;
         cnt   <= '0;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  q     <= entrada;
                  cnt   <= CNT_W'(WIDTH);
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Reloading on the last bit keeps the FSM in SHIFT for a gapless frame.
               if (cnt_last && accept) begin
                  q   <= entrada;
                  cnt <= CNT_W'(WIDTH);
               end else begin
                  q   <= shifted;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt_last) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // End-of-frame pulse: one clk after the edge that consumes the last bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fin <= 1'b0;
      end else begin
         fin <= enable && (state == ST_SHIFT) && cnt_last;
      end
   end

   // Serial output and status views of the internal state.
   always_comb begin
      if (state == ST_SHIFT) begin
         salida = LSB_FIRST ? q[0] : q[WIDTH-1];
      end else begin
         salida = IDLE_LEVEL;
      end
      ocupado    = (state == ST_SHIFT);
      pendientes = cnt;
      paralelo   = q;
   end

endmodule

// File: tb/tb_reg_piso_ctrl.sv
// Bench for reg_piso_ctrl: one LSB-first instance (idle level 0) and one
// MSB-first instance (idle level 1) driven by the same stimulus, checked
// against hand-computed per-cycle vectors.
module tb_reg_piso_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] entrada;
   logic       carga_valid;
   logic       serie_in;

   logic       rdy_l, sal_l, ocu_l, fin_l;
   logic       rdy_m, sal_m, ocu_m, fin_m;
   logic [3:0] pen_l, pen_m;
   logic [7:0] par_l, par_m;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       en;
      logic       val;
      logic [7:0] ent;
      logic       sin;
      logic       sl;    // expected LSB-first salida
      logic       sm;    // expected MSB-first salida while a frame runs
      logic [3:0] pend;
      logic       ocup;
      logic       rdy;
      logic       fin;
      logic       chkp;
      logic [7:0] par;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   reg_piso_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .enable(enable), .entrada(entrada),
      .carga_valid(carga_valid), .carga_ready(rdy_l), .serie_in(serie_in),
      .salida(sal_l), .ocupado(ocu_l), .pendientes(pen_l), .fin(fin_l),
      .paralelo(par_l)
   );

   reg_piso_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
      .clk(clk), .reset(reset), .enable(enable), .entrada(entrada),
      .carga_valid(carga_valid), .carga_ready(rdy_m), .serie_in(serie_in),
      .salida(sal_m), .ocupado(ocu_m), .pendientes(pen_m), .fin(fin_m),
      .paralelo(par_m)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void add(logic en, logic val, logic [7:0] ent, logic sin,
                               logic sl, logic sm, logic [3:0] pend, logic ocup,
                               logic rdy, logic fin, logic chkp, logic [7:0] par);
      vec_t v;
      v.en = en; v.val = val; v.ent = ent; v.sin = sin;
      v.sl = sl; v.sm = sm; v.pend = pend; v.ocup = ocup;
      v.rdy = rdy; v.fin = fin; v.chkp = chkp; v.par = par;
      tbl.push_back(v);
   endfunction

   task automatic run_table(string tag);
      foreach (tbl[i]) begin
         @(negedge clk);
         enable      = tbl[i].en;
         carga_valid = tbl[i].val;
         entrada     = tbl[i].ent;
         serie_in    = tbl[i].sin;
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d] sal_lsb", tag, i), 32'(sal_l), 32'(tbl[i].sl));
         chk($sformatf("%s[%0d] sal_msb", tag, i), 32'(sal_m),
             32'(tbl[i].ocup ? tbl[i].sm : 1'b1));
         chk($sformatf("%s[%0d] pend_lsb", tag, i), 32'(pen_l), 32'(tbl[i].pend));
         chk($sformatf("%s[%0d] pend_msb", tag, i), 32'(pen_m), 32'(tbl[i].pend));
         chk($sformatf("%s[%0d] ocup_lsb", tag, i), 32'(ocu_l), 32'(tbl[i].ocup));
         chk($sformatf("%s[%0d] ocup_msb", tag, i), 32'(ocu_m), 32'(tbl[i].ocup));
         chk($sformatf("%s[%0d] rdy_lsb", tag, i), 32'(rdy_l), 32'(tbl[i].rdy));
         chk($sformatf("%s[%0d] rdy_msb", tag, i), 32'(rdy_m), 32'(tbl[i].rdy));
         chk($sformatf("%s[%0d] fin_lsb", tag, i), 32'(fin_l), 32'(tbl[i].fin));
         chk($sformatf("%s[%0d] fin_msb", tag, i), 32'(fin_m), 32'(tbl[i].fin));
         if (tbl[i].chkp) begin
            chk($sformatf("%s[%0d] par_lsb", tag, i), 32'(par_l), 32'(tbl[i].par));
            chk($sformatf("%s[%0d] par_msb", tag, i), 32'(par_m), 32'(tbl[i].par));
         end
      end
      tbl.delete();
   endtask

   task automatic step(logic en, logic val, logic [7:0] ent, logic sin);
      @(negedge clk);
      enable = en; carga_valid = val; entrada = ent; serie_in = sin;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; carga_valid = 1'b0; entrada = '0; serie_in = 1'b0;

      // Reset state held for two clocks
      repeat (2) @(posedge clk);
      #1;
      chk("rst sal_lsb", 32'(sal_l), 32'd0);
      chk("rst sal_msb", 32'(sal_m), 32'd1);
      chk("rst rdy", 32'(rdy_l), 32'd1);
      chk("rst ocup", 32'(ocu_l), 32'd0);
      chk("rst pend", 32'(pen_l), 32'd0);
      chk("rst par", 32'(par_l), 32'd0);
      chk("rst fin", 32'(fin_l), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // A: single frame 8'h1E, zero fill
      add(1,1,8'h1E,0, 0,0,8,1,0,0, 1,8'h1E);
      add(1,0,8'h00,0, 1,0,7,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,0,6,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,5,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,4,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,1,3,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,1,2,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,1,1,1,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,1, 1,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,0, 0,8'h00);
      // B: 8'h1E then 8'hF0 back to back; early requests ignored
      add(1,1,8'h1E,0, 0,0,8,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 1,0,7,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 1,0,6,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 1,1,5,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 1,1,4,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 0,1,3,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 0,1,2,1,0,0, 0,8'h00);
      add(1,1,8'hF0,0, 0,0,1,1,1,0, 0,8'h00);
      add(1,1,8'hF0,0, 0,1,8,1,0,1, 1,8'hF0);
      add(1,0,8'h00,0, 0,1,7,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,1,6,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,1,5,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,0,4,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,0,3,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,0,2,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,0,1,1,1,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,1, 1,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,0, 0,8'h00);
      // C: 8'hA5 with enable gaps
      add(1,1,8'hA5,0, 1,1,8,1,0,0, 0,8'h00);
      add(0,0,8'h00,0, 1,1,8,1,0,0, 0,8'h00);
      add(0,0,8'h00,0, 1,1,8,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,7,1,0,0, 0,8'h00);
      add(0,0,8'h00,0, 0,0,7,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,6,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,5,1,0,0, 0,8'h00);
      add(0,0,8'h00,0, 0,0,5,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,4,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,3,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,2,1,0,0, 0,8'h00);
      add(0,0,8'h00,0, 0,0,2,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,1,1,1,0, 0,8'h00);
      add(0,0,8'h00,0, 1,1,1,1,1,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,1, 0,8'h00);
      add(0,1,8'h3C,0, 0,0,0,0,1,0, 0,8'h00);
      add(0,0,8'h00,0, 0,0,0,0,1,0, 0,8'h00);
      // D: serial fill with ones; mid-frame load request ignored
      add(1,1,8'h00,1, 0,0,8,1,0,0, 1,8'h00);
      add(1,0,8'h00,1, 0,0,7,1,0,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,6,1,0,0, 0,8'h00);
      add(1,1,8'h55,1, 0,0,5,1,0,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,4,1,0,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,3,1,0,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,2,1,0,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,1,1,1,0, 0,8'h00);
      add(1,0,8'h00,1, 0,0,0,0,1,1, 1,8'hFF);
      add(1,0,8'h00,0, 0,0,0,0,1,0, 1,8'hFF);
      run_table("main");

      // Mid-frame asynchronous reset after three bits
      step(1, 1, 8'h1E, 0);
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk("pre-abort pend", 32'(pen_l), 32'd6);
      #2;
      reset = 1'b0;
      #1;
      chk("abort sal_lsb", 32'(sal_l), 32'd0);
      chk("abort sal_msb", 32'(sal_m), 32'd1);
      chk("abort ocup", 32'(ocu_l), 32'd0);
      chk("abort pend", 32'(pen_l), 32'd0);
      chk("abort par_lsb", 32'(par_l), 32'd0);
      chk("abort par_msb", 32'(par_m), 32'd0);
      chk("abort fin", 32'(fin_l), 32'd0);
      @(posedge clk);
      #1;
      chk("abort fin next", 32'(fin_l), 32'd0);
      chk("abort fin_msb next", 32'(fin_m), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // E: normal 8'h3C frame after the abort
      add(1,1,8'h3C,0, 0,0,8,1,0,0, 1,8'h3C);
      add(1,0,8'h00,0, 0,0,7,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,6,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,5,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,4,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 1,1,3,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,2,1,0,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,1,1,1,0, 0,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,1, 1,8'h00);
      add(1,0,8'h00,0, 0,0,0,0,1,0, 0,8'h00);
      run_table("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_piso_ctrl.md
Name: reg_piso_ctrl

Overview:
Parametrised parallel-in/serial-out shift register with a built-in frame controller. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, in either bit order. It reports busy status, bits remaining and an end-of-frame pulse, and supports back-to-back frames with no idle gap. Serial transmitters in the Tema2 designs use it as the next generation of the fixed 4-bit PISO register.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 or more.
- LSB_FIRST, 1, bit order: 1 shifts out LSB first (shift right); 0 shifts out MSB first (shift left).
- IDLE_LEVEL, 0, value driven on salida when no frame is in progress.
- CNT_W (localparam), $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset; reset asserted (0) forces the reset state immediately.
- enable, input, 1, synchronous clock enable; when 0, all state holds and no handshake completes.
- entrada, input, WIDTH, parallel word to load.
- carga_valid, input, 1, load request; entrada is valid while this is high.
- carga_ready, output, 1, the block can accept a word this cycle.
- serie_in, input, 1, fill bit shifted into the vacated end on every shift.
- salida, output, 1, serial data out.
- ocupado, output, 1, a frame is in progress.
- pendientes, output, CNT_W, bits of the current frame not yet completed, including the bit now on salida.
- fin, output, 1, one-clk pulse marking frame completion.
- paralelo, output, WIDTH, current shift register contents.

Behaviour:
- Internal state is the shift register Q[WIDTH-1:0], the counter cnt, the fin flop, and a two-state FSM with states IDLE and SHIFT.
- Reset values: Q=0, cnt=0, state=IDLE, fin=0. The resulting outputs are salida=IDLE_LEVEL, ocupado=0, pendientes=0, carga_ready=1 and paralelo=0.
- A reset assertion mid-frame aborts the frame immediately, with no fin pulse.
- carga_ready = (state==IDLE) or (state==SHIFT and cnt==1). It is derived from registers only.
- A word is accepted on a rising edge when enable and carga_valid and carga_ready are all 1.
- IDLE:
  - An accept loads Q<=entrada and cnt<=WIDTH, and moves the FSM to SHIFT.
  - Without an accept, state holds.
- SHIFT, on an enable edge with cnt>1:
  - LSB_FIRST=1: Q<={serie_in, Q[WIDTH-1:1]}.
  - LSB_FIRST=0: Q<={Q[WIDTH-2:0], serie_in}.
  - cnt<=cnt-1.
- SHIFT, on an enable edge with cnt==1 (last bit):
  - With an accept: Q<=entrada, cnt<=WIDTH, stay in SHIFT. This gives a gapless back-to-back frame.
  - Without an accept: perform the normal shift (so paralelo reflects the fill), cnt<=0, go to IDLE.
- SHIFT with enable=0: everything holds, including salida.
- salida:
  - SHIFT: Q[0] when LSB_FIRST=1, Q[WIDTH-1] when LSB_FIRST=0.
  - IDLE: IDLE_LEVEL.
  - The first bit appears in the cycle right after the load edge. Each bit is held until the next enable edge.
- ocupado = (state==SHIFT). pendientes = cnt. paralelo = Q.
- fin is registered: fin <= enable and (state==SHIFT) and (cnt==1).
  - It is high for exactly one clk after the edge that consumes the last bit, regardless of enable in that cycle.
  - In back-to-back operation it pulses once per word.
- Latency: a frame occupies exactly WIDTH enabled cycles from the load edge to the return to IDLE.
- carga_valid while carga_ready=0 is ignored. entrada is not sampled and no error is flagged.
- After a frame ends without a reload, paralelo holds the last WIDTH serie_in bits, which allows SIPO reuse.

Test Plan:
- Reset value and LSB-first frame. Setup: reset=0 for 2 clks, then release; WIDTH=8, LSB_FIRST=1, enable=1; load 8'h1E. Required: during reset salida=0, carga_ready=1 and ocupado=0. After the load, salida goes 0,1,1,1,1,0,0,0 over 8 cycles; ocupado=1 and pendientes counts 8 down to 1; fin pulses once after the 8th bit; then salida=0 and ocupado=0.
- MSB-first frame. Setup: LSB_FIRST=0, load 8'h1E. Required: salida goes 0,0,0,1,1,1,1,0.
- Back-to-back frames. Setup: load 8'h1E, then hold carga_valid=1 with entrada=8'hF0. Required: 16 contiguous bits with no IDLE cycle in between; carga_ready=1 only at pendientes==1 (and IDLE); fin pulses after bit 8 and after bit 16.
- Enable gaps. Setup: load 8'hA5 and toggle enable 1,0,0,1,... through the frame. Required: salida and pendientes hold during enable=0; the bit sequence still reads 1,0,1,0,0,1,0,1; fin pulses exactly once.
- Reset mid-frame. Setup: assert reset=0 asynchronously between edges after 3 bits. Required: immediately salida=IDLE_LEVEL, ocupado=0, pendientes=0 and paralelo=0, with no fin pulse; a new load of 8'h3C afterwards runs a normal frame.
- Serial fill. Setup: load 8'h00 with serie_in=1 throughout. Required: at fin, paralelo=8'hFF; a load request arriving mid-frame with cnt>1 is ignored.
